// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants and state encoding for the multicycle divider.
package multdiv_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
endpackage

// File: rtl/negate_32bit.sv
// negate_32bit: two's-complement negation as bitwise invert plus increment.
module negate_32bit
  import multdiv_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  output logic [DIV_WIDTH-1:0] y
);
  assign y = ~a + 1'b1;
endmodule

// File: rtl/multdiv_divider.sv
// multdiv_divider: multicycle signed restoring divider, one quotient bit per cycle.
// Defining DIV_REMAINDER_EN adds the signed data_remainder output.
module multdiv_divider
  import multdiv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ctrl_div,
  input  logic [DIV_WIDTH-1:0] data_operandA,
  input  logic [DIV_WIDTH-1:0] data_operandB,
  output logic [DIV_WIDTH-1:0] data_result,
  output logic                 data_exception,
  output logic                 data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [DIV_WIDTH-1:0] data_remainder,
`endif
  output logic                 busy
);
  div_state_e state_q, state_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, bmag_q, bmag_d;
  logic [DIV_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, div0_q, div0_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [DIV_WIDTH-1:0] neg_a, neg_b, neg_quo, amag, bmag;
  logic [DIV_WIDTH:0] rem_sh, trial;
  negate_32bit u_neg_a (.a(data_operandA), .y(neg_a));
  negate_32bit u_neg_b (.a(data_operandB), .y(neg_b));
  negate_32bit u_neg_q (.a(quo_q), .y(neg_quo));
  assign amag = data_operandA[DIV_WIDTH-1] ? neg_a : data_operandA;
  assign bmag = data_operandB[DIV_WIDTH-1] ? neg_b : data_operandB;
`ifdef DIV_REMAINDER_EN
  logic [DIV_WIDTH-1:0] remout_q, remout_d, neg_rem;
  logic signa_q, signa_d;
  negate_32bit u_neg_r (.a(rem_q), .y(neg_rem));
  assign data_remainder = remout_q;
`endif
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  // rem_q stays below |B| <= 2^31, so a 33-bit trial holds the signed difference.
  assign rem_sh = {rem_q, quo_q[DIV_WIDTH-1]};
  assign trial  = rem_sh + {1'b1, ~bmag_q} + 1'b1;
  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    bmag_d   = bmag_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    div0_d   = div0_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
`ifdef DIV_REMAINDER_EN
    remout_d = remout_q;
    signa_d  = signa_q;
`endif
    case (state_q)
      RUN: begin
        quo_d   = {quo_q[DIV_WIDTH-2:0], ~trial[DIV_WIDTH]};
        rem_d   = trial[DIV_WIDTH] ? rem_sh[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(DIV_WIDTH - 1)) ? FIX : RUN;
      end
      FIX: begin
        quo_d   = div0_q ? '0 : sign_q ? neg_quo : quo_q;
`ifdef DIV_REMAINDER_EN
        // With a zero divisor every trial succeeds, leaving rem_q = |A|, so this restores A.
        rem_d   = signa_q ? neg_rem : rem_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        result_d = quo_q;
        exc_d    = div0_q;
        rdy_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
`ifdef DIV_REMAINDER_EN
        remout_d = rem_q;
`endif
      end
      default: ;
    endcase
    if (ctrl_div) begin
      state_d = RUN;
      quo_d   = amag;
      bmag_d  = bmag;
      rem_d   = '0;
      cnt_d   = '0;
      sign_d  = data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
      div0_d  = (data_operandB == '0);
      busy_d  = 1'b1;
`ifdef DIV_REMAINDER_EN
      signa_d = data_operandA[DIV_WIDTH-1];
`endif
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      bmag_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
      remout_q <= '0;
      signa_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      bmag_q   <= bmag_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef DIV_REMAINDER_EN
      remout_q <= remout_d;
      signa_q  <= signa_d;
`endif
    end
  end
endmodule

// File: tb/tb_multdiv_divider.sv
// tb_multdiv_divider: directed checks of latency, signs, divide-by-zero, abort and restart.
module tb_multdiv_divider;
  logic clock = 1'b0;
  logic reset, ctrl_div;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] pa [8] = '{32'd4294967196, 32'h80000000, 32'd55, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFF9C};
  logic [31:0] pb [8] = '{32'd7, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'h10, 32'd0};
  logic [31:0] pq [8] = '{32'hFFFFFFF2, 32'h80000000, 32'd0, 32'd3, 32'd0, 32'd1, 32'h07FFFFFF, 32'd0};
  logic [31:0] pr [8] = '{32'hFFFFFFFE, 32'd0, 32'd55, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hF, 32'hFFFFFF9C};
  logic        pe [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  multdiv_divider dut (
    .clock(clock), .reset(reset), .ctrl_div(ctrl_div),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
`ifdef DIV_REMAINDER_EN
    .data_remainder(data_remainder),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_div = 1'b1; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_div = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (data_resultRDY !== 1'b1 && k < 60);
  endtask

  task automatic test_reset;
    reset = 1'b1; ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    repeat (2) @(negedge clock);
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'b0) begin
      miscompares++;
      $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b want all 0", data_result, data_exception, data_resultRDY, busy);
    end
    ctrl_div = 1'b0; reset = 1'b0;
  endtask

  task automatic test_basic;
    logic eb, er;
    start(32'd100, 32'd7);
    for (int k = 0; k <= 35; k++) begin
      eb = (k <= 33); er = (k == 34);
      vectors += 2;
      if (busy !== eb) begin miscompares++; $display("FAIL basic_busy k=%0d: got %b want %b", k, busy, eb); end
      if (data_resultRDY !== er) begin miscompares++; $display("FAIL basic_rdy k=%0d: got %b want %b", k, data_resultRDY, er); end
      if (k == 34) begin
        vectors += 2;
        if (data_result !== 32'd14) begin miscompares++; $display("FAIL basic_result: got %h want %h", data_result, 32'd14); end
        if (data_exception !== 1'b0) begin miscompares++; $display("FAIL basic_exc: got %b want 0", data_exception); end
`ifdef DIV_REMAINDER_EN
        vectors++;
        if (data_remainder !== 32'd2) begin miscompares++; $display("FAIL basic_rem: got %h want 2", data_remainder); end
`endif
      end
      @(negedge clock);
    end
  endtask

  task automatic test_patterns;
    int k;
    for (int i = 0; i < 8; i++) begin
      start(pa[i], pb[i]);
      wait_rdy(k);
      vectors += 3;
      if (k !== 34) begin miscompares++; $display("FAIL pat%0d_latency: got %0d want 34", i, k); end
      if (data_result !== pq[i]) begin miscompares++; $display("FAIL pat%0d_result: got %h want %h", i, data_result, pq[i]); end
      if (data_exception !== pe[i]) begin miscompares++; $display("FAIL pat%0d_exc: got %b want %b", i, data_exception, pe[i]); end
`ifdef DIV_REMAINDER_EN
      vectors++;
      if (data_remainder !== pr[i]) begin miscompares++; $display("FAIL pat%0d_rem: got %h want %h", i, data_remainder, pr[i]); end
`endif
    end
    repeat (5) @(negedge clock);
    vectors += 2;
    if (data_result !== pq[7] || data_exception !== 1'b1) begin
      miscompares++; $display("FAIL hold: got %h/%b want %h/1", data_result, data_exception, pq[7]);
    end
    if (data_resultRDY !== 1'b0) begin miscompares++; $display("FAIL hold_rdy: got %b want 0", data_resultRDY); end
  endtask

  task automatic test_mid_reset;
    int seen;
    start(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'b0) begin
      miscompares++;
      $display("FAIL midreset_state: got res=%h exc=%b rdy=%b busy=%b want all 0", data_result, data_exception, data_resultRDY, busy);
    end
    seen = 0;
    for (int k = 11; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midreset_rdy: got %0d pulses want 0", seen); end
  endtask

  task automatic test_restart;
    int first;
    logic [31:0] res;
    start(32'd100, 32'd7);
    repeat (4) @(negedge clock);
    ctrl_div = 1'b1; data_operandA = 32'd9; data_operandB = 32'hFFFFFFFD;
    @(negedge clock);
    ctrl_div = 1'b0;
    first = -1; res = '0;
    for (int k = 6; k <= 45; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1 && first < 0) begin first = k; res = data_result; end
    end
    vectors += 2;
    if (first !== 39) begin miscompares++; $display("FAIL restart_latency: got %0d want 39", first); end
    if (res !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL restart_result: got %h want fffffffd", res); end
  endtask

  task automatic test_back_to_back;
    int k;
    start(32'd20, 32'd3);
    repeat (33) @(negedge clock);
    ctrl_div = 1'b1; data_operandA = 32'hFFFFFFF9; data_operandB = 32'd2;
    @(negedge clock);
    ctrl_div = 1'b0;
    vectors += 3;
    if (data_resultRDY !== 1'b1) begin miscompares++; $display("FAIL b2b_old_rdy: got %b want 1", data_resultRDY); end
    if (data_result !== 32'd6) begin miscompares++; $display("FAIL b2b_old_result: got %h want 6", data_result); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b want 1", busy); end
`ifdef DIV_REMAINDER_EN
    vectors++;
    if (data_remainder !== 32'd2) begin miscompares++; $display("FAIL b2b_old_rem: got %h want 2", data_remainder); end
`endif
    wait_rdy(k);
    vectors += 2;
    if (k !== 34) begin miscompares++; $display("FAIL b2b_new_latency: got %0d want 34", k); end
    if (data_result !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL b2b_new_result: got %h want fffffffd", data_result); end
`ifdef DIV_REMAINDER_EN
    vectors++;
    if (data_remainder !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL b2b_new_rem: got %h want ffffffff", data_remainder); end
`endif
  endtask

  initial begin
    reset = 1'b1; ctrl_div = 1'b0; data_operandA = '0; data_operandB = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_mid_reset();
    test_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
